// File: rtl/cpa_accumulator.sv
// cpa_accumulator: resolves the compressor tree's redundant sum/carry pair with a
// carry-propagate add, accumulates a programmable number of these partials into one
// signed dot-product value, and offers the result on a valid/ready output.
// Optional build macro CPA_ACC_SAT_EN: saturating accumulation with a sticky
// overflow flag. Without it the accumulator wraps and overflow_o is tied to 0.
module cpa_accumulator #(
  parameter int IN_SIZE  = 20,
  parameter int ACC_SIZE = 32,
  parameter int LEN_SIZE = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [IN_SIZE-1:0]  sum_i,
  input  logic [IN_SIZE-1:0]  carry_i,
  input  logic [LEN_SIZE-1:0] len_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [ACC_SIZE-1:0] acc_o,
  output logic                overflow_o,
  output logic                valid_o,
  input  logic                ready_i
);

  // Partials are sign-extended into the accumulator, so it can never be narrower.
  if (ACC_SIZE < IN_SIZE) begin : g_bad_acc_size
    $error("cpa_accumulator: ACC_SIZE must be >= IN_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [LEN_SIZE-1:0] LEN_ONE = LEN_SIZE'(1);

  state_t              state_q, state_d;
  logic [ACC_SIZE-1:0] acc_q;
  logic [LEN_SIZE-1:0] cnt_q;
  logic [LEN_SIZE-1:0] len_q;
  logic [LEN_SIZE-1:0] len_new;
  logic [IN_SIZE-1:0]  partial_raw;
  logic [ACC_SIZE-1:0] partial;
  logic [ACC_SIZE-1:0] sum_wrap;
  logic [ACC_SIZE-1:0] acc_add;
  logic                beat;
  logic                start;
  logic                accum;

  // Carry-propagate add, truncated to the compressor width, then sign-extended.
  assign partial_raw = sum_i + carry_i;
  assign partial     = ACC_SIZE'($signed(partial_raw));
  assign sum_wrap    = acc_q + partial;

  // A zero length is treated as a single-partial result.
  assign len_new = (len_i == '0) ? LEN_ONE : len_i;

  // Handshake: HOLD only accepts a new beat while its own result is being taken.
  assign ready_o = (state_q == HOLD) ? ready_i : 1'b1;
  assign valid_o = (state_q == HOLD);
  assign acc_o   = acc_q;

  // A beat inside a clear cycle is discarded; start/accum are mutually exclusive.
  assign beat  = valid_i && ready_o && !clear_i;
  assign start = beat && (state_q == IDLE || state_q == HOLD);
  assign accum = beat && (state_q == ACC);

`ifdef CPA_ACC_SAT_EN
  logic pos_ovf;
  logic neg_ovf;
  logic ovf_q;

  // Same-sign operands producing an opposite-sign sum mark a signed overflow.
  assign pos_ovf = !acc_q[ACC_SIZE-1] && !partial[ACC_SIZE-1] &&  sum_wrap[ACC_SIZE-1];
  assign neg_ovf =  acc_q[ACC_SIZE-1] &&  partial[ACC_SIZE-1] && !sum_wrap[ACC_SIZE-1];
  assign acc_add = pos_ovf ? {1'b0, {(ACC_SIZE-1){1'b1}}} :
                   neg_ovf ? {1'b1, {(ACC_SIZE-1){1'b0}}} : sum_wrap;

  // Sticky overflow flag, restarted with each new result and on abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (clear_i || start) begin
      ovf_q <= 1'b0;
    end else if (accum) begin
      ovf_q <= ovf_q | pos_ovf | neg_ovf;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign acc_add    = sum_wrap;
  assign overflow_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear_i overrides every transition.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = (len_new == LEN_ONE) ? HOLD : ACC;
        end
        ACC: begin
          if (accum && (cnt_q + LEN_ONE == len_q)) state_d = HOLD;
        end
        HOLD: begin
          if (ready_i) begin
            if (start) state_d = (len_new == LEN_ONE) ? HOLD : ACC;
            else       state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accumulator, beat counter and latched length. acc survives an abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start) begin
      acc_q <= partial;
      cnt_q <= LEN_ONE;
      len_q <= len_new;
    end else if (accum) begin
      acc_q <= acc_add;
      cnt_q <= cnt_q + LEN_ONE;
    end
  end

endmodule
